// File: rtl/pipelined_control_unit.sv
// ============================================================================
// pipelined_control_unit: D-stage decode carried through E/M/W with
// stall/flush, E-stage branch decision and saturating illegal counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipelined_control_unit #(
    parameter int ALU_CTRL_W = 3,
    parameter int CNT_W      = 8,
    parameter bit JAL_EN     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            opcode_D,
    input  logic [2:0]            funct3_D,
    input  logic                  funct7_5_D,
    input  logic                  valid_D,
    input  logic                  stall_E,
    input  logic                  flush_E,
    input  logic                  zero_E,
    output logic [1:0]            imm_src_D,
    output logic                  illegal_D,
    output logic                  reg_WE_E,
    output logic                  mem_WE_E,
    output logic                  ALU_srcB_E,
    output logic                  branch_E,
    output logic                  jump_E,
    output logic [1:0]            result_src_E,
    output logic [ALU_CTRL_W-1:0] ALU_control_E,
    output logic                  pc_src_E,
    output logic                  reg_WE_M,
    output logic                  mem_WE_M,
    output logic [1:0]            result_src_M,
    output logic                  reg_WE_W,
    output logic [1:0]            result_src_W,
    output logic [CNT_W-1:0]      illegal_count
);

    localparam logic [6:0] C_OP_LW  = 7'b0000011;
    localparam logic [6:0] C_OP_SW  = 7'b0100011;
    localparam logic [6:0] C_OP_R   = 7'b0110011;
    localparam logic [6:0] C_OP_I   = 7'b0010011;
    localparam logic [6:0] C_OP_BEQ = 7'b1100011;
    localparam logic [6:0] C_OP_JAL = 7'b1101111;

    localparam logic [2:0] C_ALU_ADD = 3'b000;
    localparam logic [2:0] C_ALU_SUB = 3'b001;
    localparam logic [2:0] C_ALU_AND = 3'b010;
    localparam logic [2:0] C_ALU_OR  = 3'b011;
    localparam logic [2:0] C_ALU_SLT = 3'b101;

    typedef struct packed {
        logic                  reg_we;
        logic                  mem_we;
        logic                  srcb;
        logic                  branch;
        logic                  jump;
        logic [1:0]            result_src;
        logic [ALU_CTRL_W-1:0] alu;
    } ctrl_t;

    typedef struct packed {
        logic       reg_we;
        logic       mem_we;
        logic [1:0] result_src;
    } ctrl_m_t;

    typedef struct packed {
        logic       reg_we;
        logic [1:0] result_src;
    } ctrl_w_t;

    ctrl_t                 dec_d;
    ctrl_t                 e_d, e_q;
    ctrl_m_t               m_d, m_q;
    ctrl_w_t               w_q;
    logic [CNT_W-1:0]      cnt_d, cnt_q;
    logic [1:0]            imm_d;
    logic                  legal_d;
    logic                  alu_ok_d;
    logic [2:0]            alu3_d;
    logic [ALU_CTRL_W-1:0] alu_ext_d;

    always_comb begin
        alu3_d   = C_ALU_ADD;
        alu_ok_d = 1'b1;
        case (funct3_D)
            3'b000:  alu3_d = (opcode_D == C_OP_R && funct7_5_D) ? C_ALU_SUB : C_ALU_ADD;
            3'b010:  alu3_d = C_ALU_SLT;
            3'b110:  alu3_d = C_ALU_OR;
            3'b111:  alu3_d = C_ALU_AND;
            default: alu_ok_d = 1'b0;
        endcase
        alu_ext_d      = '0;
        alu_ext_d[2:0] = alu3_d;
    end

    always_comb begin
        dec_d   = '0;
        imm_d   = 2'b00;
        legal_d = 1'b0;
        case (opcode_D)
            C_OP_LW: begin
                legal_d          = 1'b1;
                dec_d.reg_we     = 1'b1;
                dec_d.srcb       = 1'b1;
                dec_d.result_src = 2'b01;
            end
            C_OP_SW: begin
                legal_d      = 1'b1;
                dec_d.mem_we = 1'b1;
                dec_d.srcb   = 1'b1;
                imm_d        = 2'b01;
            end
            C_OP_R: begin
                legal_d      = alu_ok_d;
                dec_d.reg_we = 1'b1;
                dec_d.alu    = alu_ext_d;
            end
            C_OP_I: begin
                legal_d      = alu_ok_d;
                dec_d.reg_we = 1'b1;
                dec_d.srcb   = 1'b1;
                dec_d.alu    = alu_ext_d;
            end
            C_OP_BEQ: begin
                legal_d        = (funct3_D == 3'b000);
                dec_d.branch   = 1'b1;
                dec_d.alu      = '0;
                dec_d.alu[2:0] = C_ALU_SUB;
                imm_d          = 2'b10;
            end
            C_OP_JAL: begin
                legal_d          = JAL_EN;
                dec_d.reg_we     = 1'b1;
                dec_d.jump       = 1'b1;
                dec_d.result_src = 2'b10;
                imm_d            = 2'b11;
            end
            default: legal_d = 1'b0;
        endcase
        // Anything not issued as a legal, valid instruction becomes a bubble.
        if (!(legal_d && valid_D)) begin
            dec_d = '0;
            imm_d = 2'b00;
        end
    end

    assign imm_src_D = imm_d;
    assign illegal_D = valid_D & ~legal_d;

    always_comb begin
        e_d = dec_d;
        if (flush_E) begin
            e_d = '0;
        end else if (stall_E) begin
            e_d = e_q;
        end
        m_d = '{reg_we: e_q.reg_we, mem_we: e_q.mem_we, result_src: e_q.result_src};
        if (stall_E && !flush_E) begin
            m_d = '0;
        end
        cnt_d = cnt_q;
        if (illegal_D && !flush_E && !stall_E && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            e_q   <= '0;
            m_q   <= '0;
            w_q   <= '0;
            cnt_q <= '0;
        end else begin
            e_q   <= e_d;
            m_q   <= m_d;
            w_q   <= '{reg_we: m_q.reg_we, result_src: m_q.result_src};
            cnt_q <= cnt_d;
        end
    end

    assign reg_WE_E      = e_q.reg_we;
    assign mem_WE_E      = e_q.mem_we;
    assign ALU_srcB_E    = e_q.srcb;
    assign branch_E      = e_q.branch;
    assign jump_E        = e_q.jump;
    assign result_src_E  = e_q.result_src;
    assign ALU_control_E = e_q.alu;
    assign pc_src_E      = (e_q.branch & zero_E) | e_q.jump;
    assign reg_WE_M      = m_q.reg_we;
    assign mem_WE_M      = m_q.mem_we;
    assign result_src_M  = m_q.result_src;
    assign reg_WE_W      = w_q.reg_we;
    assign result_src_W  = w_q.result_src;
    assign illegal_count = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pipelined_control_unit.sv
// ============================================================================
// tb_pipelined_control_unit: directed vectors with a queued scoreboard.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pipelined_control_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode_D;
    logic [2:0] funct3_D;
    logic       funct7_5_D, valid_D, stall_E, flush_E, zero_E;

    logic [1:0] imm_src_D;
    logic       illegal_D, reg_WE_E, mem_WE_E, ALU_srcB_E, branch_E, jump_E;
    logic [1:0] result_src_E;
    logic [2:0] ALU_control_E;
    logic       pc_src_E, reg_WE_M, mem_WE_M;
    logic [1:0] result_src_M;
    logic       reg_WE_W;
    logic [1:0] result_src_W;
    logic [7:0] illegal_count;

    logic [1:0] j0_imm;
    logic       j0_ill, j0_rwe, j0_mwe, j0_srcb, j0_br, j0_jmp;
    logic [1:0] j0_rs_e;
    logic [2:0] j0_alu;
    logic       j0_pc, j0_rwe_m, j0_mwe_m;
    logic [1:0] j0_rs_m;
    logic       j0_rwe_w;
    logic [1:0] j0_rs_w;
    logic [7:0] j0_cnt;

    always #5 clk = ~clk;

    pipelined_control_unit #(.ALU_CTRL_W(3), .CNT_W(8), .JAL_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .opcode_D(opcode_D), .funct3_D(funct3_D),
        .funct7_5_D(funct7_5_D), .valid_D(valid_D), .stall_E(stall_E),
        .flush_E(flush_E), .zero_E(zero_E), .imm_src_D(imm_src_D),
        .illegal_D(illegal_D), .reg_WE_E(reg_WE_E), .mem_WE_E(mem_WE_E),
        .ALU_srcB_E(ALU_srcB_E), .branch_E(branch_E), .jump_E(jump_E),
        .result_src_E(result_src_E), .ALU_control_E(ALU_control_E),
        .pc_src_E(pc_src_E), .reg_WE_M(reg_WE_M), .mem_WE_M(mem_WE_M),
        .result_src_M(result_src_M), .reg_WE_W(reg_WE_W),
        .result_src_W(result_src_W), .illegal_count(illegal_count)
    );

    pipelined_control_unit #(.ALU_CTRL_W(3), .CNT_W(8), .JAL_EN(1'b0)) dut_nojal (
        .clk(clk), .rst_n(rst_n), .opcode_D(opcode_D), .funct3_D(funct3_D),
        .funct7_5_D(funct7_5_D), .valid_D(valid_D), .stall_E(stall_E),
        .flush_E(flush_E), .zero_E(zero_E), .imm_src_D(j0_imm),
        .illegal_D(j0_ill), .reg_WE_E(j0_rwe), .mem_WE_E(j0_mwe),
        .ALU_srcB_E(j0_srcb), .branch_E(j0_br), .jump_E(j0_jmp),
        .result_src_E(j0_rs_e), .ALU_control_E(j0_alu),
        .pc_src_E(j0_pc), .reg_WE_M(j0_rwe_m), .mem_WE_M(j0_mwe_m),
        .result_src_M(j0_rs_m), .reg_WE_W(j0_rwe_w),
        .result_src_W(j0_rs_w), .illegal_count(j0_cnt)
    );

    typedef struct {
        logic       ill;
        logic [1:0] imm;
        logic [9:0] e;   // {regWE, memWE, srcB, branch, jump, resultSrc[1:0], alu[2:0]}
        logic       pc;
        logic [3:0] m;   // {regWE, memWE, resultSrc[1:0]}
        logic [2:0] w;   // {regWE, resultSrc[1:0]}
        logic [7:0] cnt;
        logic       j0;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   stim_done = 1'b0;

    localparam logic [9:0] C_LW   = 10'b10100_01_000;
    localparam logic [9:0] C_SW   = 10'b01100_00_000;
    localparam logic [9:0] C_SUB  = 10'b10000_00_001;
    localparam logic [9:0] C_AND  = 10'b10000_00_010;
    localparam logic [9:0] C_ADDI = 10'b10100_00_000;
    localparam logic [9:0] C_BEQ  = 10'b00010_00_001;
    localparam logic [9:0] C_JAL  = 10'b10001_10_000;

    localparam logic [6:0] C_OP_LW  = 7'b0000011;
    localparam logic [6:0] C_OP_SW  = 7'b0100011;
    localparam logic [6:0] C_OP_R   = 7'b0110011;
    localparam logic [6:0] C_OP_I   = 7'b0010011;
    localparam logic [6:0] C_OP_BEQ = 7'b1100011;
    localparam logic [6:0] C_OP_JAL = 7'b1101111;
    localparam logic [6:0] C_OP_BAD = 7'b1111111;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Inputs are held across one rising edge; expectations describe the outputs after it.
    task automatic vec(input logic r, input logic [6:0] op, input logic [2:0] f3,
                       input logic f7, input logic v, input logic st, input logic fl,
                       input logic z, input logic ill, input logic [1:0] imm,
                       input logic [9:0] e, input logic pc, input logic [3:0] m,
                       input logic [2:0] w, input logic [7:0] cnt, input logic j0);
        exp_t x;
        @(negedge clk);
        rst_n = r; opcode_D = op; funct3_D = f3; funct7_5_D = f7;
        valid_D = v; stall_E = st; flush_E = fl; zero_E = z;
        x = '{ill: ill, imm: imm, e: e, pc: pc, m: m, w: w, cnt: cnt, j0: j0};
        exp_q.push_back(x);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("illegal_D", {31'd0, illegal_D}, {31'd0, x.ill});
                chk("imm_src_D", {30'd0, imm_src_D}, {30'd0, x.imm});
                chk("E_word", {22'd0, reg_WE_E, mem_WE_E, ALU_srcB_E, branch_E, jump_E,
                               result_src_E, ALU_control_E}, {22'd0, x.e});
                chk("pc_src_E", {31'd0, pc_src_E}, {31'd0, x.pc});
                chk("M_word", {28'd0, reg_WE_M, mem_WE_M, result_src_M}, {28'd0, x.m});
                chk("W_word", {29'd0, reg_WE_W, result_src_W}, {29'd0, x.w});
                chk("illegal_count", {24'd0, illegal_count}, {24'd0, x.cnt});
                if (x.j0) begin
                    chk("nojal_illegal", {27'd0, j0_ill, j0_rwe, j0_mwe, j0_jmp, j0_pc},
                        32'b10000);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [7:0] exp_cnt;
        rst_n = 1'b0; opcode_D = '0; funct3_D = '0; funct7_5_D = 1'b0;
        valid_D = 1'b0; stall_E = 1'b0; flush_E = 1'b0; zero_E = 1'b0;
        //  r  op        f3      f7 v  st fl z   ill imm    E       pc M        W       cnt j0
        vec(0, 7'd0,     3'b000, 0, 0, 0, 0, 0,  0, 2'b00, 10'd0,  0, 4'b0000, 3'b000, 0, 0);
        vec(0, 7'd0,     3'b000, 0, 0, 0, 0, 0,  0, 2'b00, 10'd0,  0, 4'b0000, 3'b000, 0, 0);
        vec(1, C_OP_LW,  3'b010, 0, 1, 0, 0, 0,  0, 2'b00, C_LW,   0, 4'b0000, 3'b000, 0, 0);
        vec(1, C_OP_R,   3'b000, 1, 1, 0, 0, 0,  0, 2'b00, C_SUB,  0, 4'b1001, 3'b000, 0, 0);
        vec(1, C_OP_R,   3'b111, 0, 1, 0, 0, 0,  0, 2'b00, C_AND,  0, 4'b1000, 3'b101, 0, 0);
        vec(1, C_OP_I,   3'b000, 1, 1, 0, 0, 0,  0, 2'b00, C_ADDI, 0, 4'b1000, 3'b100, 0, 0);
        vec(1, C_OP_BEQ, 3'b000, 0, 1, 0, 0, 1,  0, 2'b10, C_BEQ,  1, 4'b1000, 3'b100, 0, 0);
        vec(1, C_OP_BEQ, 3'b000, 0, 1, 0, 0, 0,  0, 2'b10, C_BEQ,  0, 4'b0000, 3'b100, 0, 0);
        vec(1, C_OP_JAL, 3'b000, 0, 1, 0, 0, 0,  0, 2'b11, C_JAL,  1, 4'b0000, 3'b000, 0, 1);
        vec(1, C_OP_LW,  3'b010, 0, 1, 0, 0, 0,  0, 2'b00, C_LW,   0, 4'b1010, 3'b000, 0, 0);
        vec(1, C_OP_SW,  3'b010, 0, 1, 1, 0, 0,  0, 2'b01, C_LW,   0, 4'b0000, 3'b110, 0, 0);
        vec(1, C_OP_SW,  3'b010, 0, 1, 1, 0, 0,  0, 2'b01, C_LW,   0, 4'b0000, 3'b000, 0, 0);
        vec(1, C_OP_SW,  3'b010, 0, 1, 0, 0, 0,  0, 2'b01, C_SW,   0, 4'b1001, 3'b000, 0, 0);
        vec(1, C_OP_LW,  3'b010, 0, 1, 1, 1, 0,  0, 2'b00, 10'd0,  0, 4'b0100, 3'b101, 0, 0);
        vec(1, C_OP_BAD, 3'b000, 0, 1, 0, 1, 0,  1, 2'b00, 10'd0,  0, 4'b0000, 3'b000, 0, 0);
        vec(1, C_OP_BAD, 3'b000, 0, 1, 0, 0, 0,  1, 2'b00, 10'd0,  0, 4'b0000, 3'b000, 1, 0);
        vec(1, C_OP_BAD, 3'b000, 0, 1, 1, 0, 0,  1, 2'b00, 10'd0,  0, 4'b0000, 3'b000, 1, 0);
        vec(1, C_OP_R,   3'b001, 0, 1, 0, 0, 0,  1, 2'b00, 10'd0,  0, 4'b0000, 3'b000, 2, 0);
        vec(1, C_OP_LW,  3'b010, 0, 0, 0, 0, 0,  0, 2'b00, 10'd0,  0, 4'b0000, 3'b000, 2, 0);
        vec(1, C_OP_LW,  3'b010, 0, 1, 0, 0, 0,  0, 2'b00, C_LW,   0, 4'b0000, 3'b000, 2, 0);
        vec(1, C_OP_I,   3'b000, 0, 1, 0, 0, 0,  0, 2'b00, C_ADDI, 0, 4'b1001, 3'b000, 2, 0);
        vec(0, C_OP_LW,  3'b010, 0, 1, 1, 0, 0,  0, 2'b00, 10'd0,  0, 4'b0000, 3'b000, 0, 0);
        vec(1, C_OP_LW,  3'b010, 0, 0, 0, 0, 0,  0, 2'b00, 10'd0,  0, 4'b0000, 3'b000, 0, 0);
        // Illegal stream long enough to saturate the 8-bit counter.
        for (int i = 0; i < 300; i++) begin
            exp_cnt = (i >= 254) ? 8'd255 : 8'(i + 1);
            vec(1, C_OP_BAD, 3'b000, 0, 1, 0, 0, 0, 1, 2'b00, 10'd0, 0, 4'b0000, 3'b000, exp_cnt, 0);
        end
        vec(1, C_OP_BAD, 3'b000, 0, 1, 0, 1, 0,  1, 2'b00, 10'd0,  0, 4'b0000, 3'b000, 255, 0);
        vec(0, C_OP_BAD, 3'b000, 0, 1, 0, 0, 0,  1, 2'b00, 10'd0,  0, 4'b0000, 3'b000, 0, 0);
        stim_done = 1'b1;
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
